// File: rtl/memory_interface.sv
// Memory-side responder for the MFA/MFC handshake: byte-addressed word/byte RAM access
// after WAIT_CYCLES wait states. Optional macro MEMIF_SIGN_EXTEND_EN sign-extends byte reads.
module memory_interface #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  MFA,
    input  logic                  READ_WRITE,
    input  logic                  WORD_BYTE,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  MFC,
    output logic                  Fault
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic                  wb_q, wb_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           dout_q, dout_d;
    logic                  fault_q, fault_d;

    logic [31:0] mem [0:DEPTH-1];

    logic                  use_live;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_rw;
    logic                  acc_wb;
    logic [31:0]           acc_wdata;
    logic [ADDR_WIDTH-3:0] acc_idx;
    logic [4:0]            lane_shift;
    logic [31:0]           rd_word;
    logic [31:0]           rd_shifted;
    logic [7:0]            rd_byte;
    logic [31:0]           byte_ext;
    logic [31:0]           lane_mask;
    logic [31:0]           wr_word;
    logic                  misaligned;
    logic                  do_access;
    logic                  mem_we;

    // With zero wait states the access happens on the sampling edge, so it must see the live inputs.
    assign use_live   = (WAIT_CYCLES == 0) && (state_q == IDLE);
    assign acc_addr   = use_live ? Address    : addr_q;
    assign acc_rw     = use_live ? READ_WRITE : rw_q;
    assign acc_wb     = use_live ? WORD_BYTE  : wb_q;
    assign acc_wdata  = use_live ? DataIn     : wdata_q;

    assign acc_idx    = acc_addr[ADDR_WIDTH-1:2];
    assign lane_shift = {~acc_addr[1:0], 3'b000};
    assign rd_word    = mem[acc_idx];
    assign rd_shifted = rd_word >> lane_shift;
    assign rd_byte    = rd_shifted[7:0];
    assign lane_mask  = 32'h0000_00FF << lane_shift;
    assign wr_word    = acc_wb ? acc_wdata
                               : ((rd_word & ~lane_mask) | ({24'b0, acc_wdata[7:0]} << lane_shift));
    assign misaligned = acc_wb && (acc_addr[1:0] != 2'b00);

`ifdef MEMIF_SIGN_EXTEND_EN
    assign byte_ext = {{24{rd_byte[7]}}, rd_byte};
`else
    assign byte_ext = {24'b0, rd_byte};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wb_d      = wb_q;
        wdata_d   = wdata_q;
        dout_d    = dout_q;
        fault_d   = fault_q;
        do_access = 1'b0;

        case (state_q)
            IDLE: begin
                if (MFA) begin
                    addr_d  = Address;
                    rw_d    = READ_WRITE;
                    wb_d    = WORD_BYTE;
                    wdata_d = DataIn;
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        state_d   = DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!MFA) begin
                    state_d = IDLE;
                    fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_access) begin
            if (misaligned) begin
                fault_d = 1'b1;
                dout_d  = 32'd0;
            end else begin
                fault_d = 1'b0;
                dout_d  = acc_rw ? (acc_wb ? rd_word : byte_ext) : 32'd0;
            end
        end
    end

    // Gating with Reset keeps an aborted request from committing on the edge where reset is held.
    assign mem_we = do_access && !acc_rw && !misaligned && !Reset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wb_q    <= 1'b0;
            wdata_q <= 32'd0;
            dout_q  <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wb_q    <= wb_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[acc_idx] <= wr_word;
        end
    end

    assign MFC     = (state_q == DONE);
    assign Fault   = fault_q;
    assign DataOut = dout_q;

endmodule

// File: tb/tb_memory_interface.sv
// Directed self-checking bench for memory_interface (WAIT_CYCLES = 2) using immediate assertions.
module tb_memory_interface;

    logic        Clk;
    logic        Reset;
    logic        MFA;
    logic        READ_WRITE;
    logic        WORD_BYTE;
    logic [9:0]  Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MFC;
    logic        Fault;

    int numTests;
    int numFail;

`ifdef MEMIF_SIGN_EXTEND_EN
    localparam logic [31:0] BYTE_AD = 32'hFFFF_FFAD;
`else
    localparam logic [31:0] BYTE_AD = 32'h0000_00AD;
`endif

    memory_interface #(
        .ADDR_WIDTH (10),
        .WAIT_CYCLES(2)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .MFA       (MFA),
        .READ_WRITE(READ_WRITE),
        .WORD_BYTE (WORD_BYTE),
        .Address   (Address),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .MFC       (MFC),
        .Fault     (Fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkBit(input string tag, input logic got, input logic exp);
        numTests++;
        assert (got === exp) else begin
            numFail++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic checkWord(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numTests++;
        assert (got === exp) else begin
            numFail++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expMfc, input logic expFault,
                               input logic [31:0] expData);
        checkBit({tag, ".MFC"}, MFC, expMfc);
        checkBit({tag, ".Fault"}, Fault, expFault);
        checkWord({tag, ".DataOut"}, DataOut, expData);
    endtask

    task automatic applyStimulus(input logic mfa, input logic rw, input logic wb,
                                 input logic [9:0] addr, input logic [31:0] data);
        @(negedge Clk);
        MFA        = mfa;
        READ_WRITE = rw;
        WORD_BYTE  = wb;
        Address    = addr;
        DataIn     = data;
    endtask

    // Full four-phase transaction with exact-latency checks on MFC.
    task automatic runAccess(input string tag, input logic rw, input logic wb,
                             input logic [9:0] addr, input logic [31:0] data,
                             input logic [31:0] expData, input logic expFault);
        applyStimulus(1'b1, rw, wb, addr, data);
        @(posedge Clk); #1;
        checkBit({tag, ".MFC_k0"}, MFC, 1'b0);
        @(posedge Clk); #1;
        checkBit({tag, ".MFC_k1"}, MFC, 1'b0);
        @(posedge Clk); #1;
        checkOutput({tag, ".done"}, 1'b1, expFault, expData);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
        @(posedge Clk); #1;
        checkOutput({tag, ".release"}, 1'b0, 1'b0, expData);
    endtask

    initial begin
        numTests   = 0;
        numFail    = 0;
        Reset      = 1'b0;
        MFA        = 1'b0;
        READ_WRITE = 1'b0;
        WORD_BYTE  = 1'b0;
        Address    = 10'h000;
        DataIn     = 32'h0;

        #2 Reset = 1'b1;
        #1;
        checkOutput("reset_init", 1'b0, 1'b0, 32'h0);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        runAccess("wr_word_010", 1'b0, 1'b1, 10'h010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        runAccess("rd_word_010", 1'b1, 1'b1, 10'h010, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Asynchronous reset while idle with non-zero DataOut held
        #2 Reset = 1'b1;
        #1;
        checkOutput("reset_idle", 1'b0, 1'b0, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        runAccess("rd_byte_011", 1'b1, 1'b0, 10'h011, 32'h0, BYTE_AD, 1'b0);
        runAccess("wr_byte_013", 1'b0, 1'b0, 10'h013, 32'hFFFF_FF5A, 32'h0, 1'b0);
        runAccess("rd_word_after_byte", 1'b1, 1'b1, 10'h010, 32'h0, 32'hDEAD_BE5A, 1'b0);
        runAccess("rd_misaligned_012", 1'b1, 1'b1, 10'h012, 32'h0, 32'h0, 1'b1);
        runAccess("rd_word_pre_misw", 1'b1, 1'b1, 10'h010, 32'h0, 32'hDEAD_BE5A, 1'b0);
        runAccess("wr_misaligned_012", 1'b0, 1'b1, 10'h012, 32'h1234_5678, 32'h0, 1'b1);
        runAccess("rd_word_after_misw", 1'b1, 1'b1, 10'h010, 32'h0, 32'hDEAD_BE5A, 1'b0);
        runAccess("rd_byte_010", 1'b1, 1'b0, 10'h010, 32'h0, 32'h0000_00DE, 1'b0);

        // MFA held high in DONE with changing inputs must not trigger another access
        applyStimulus(1'b1, 1'b0, 1'b1, 10'h020, 32'hCAFE_F00D);
        @(posedge Clk);
        @(posedge Clk);
        @(posedge Clk); #1;
        checkOutput("hold_enter", 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 10'h020, 32'h5555_0000 + 32'(i));
            @(posedge Clk); #1;
            checkOutput($sformatf("hold_cycle%0d", i), 1'b1, 1'b0, 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
        @(posedge Clk); #1;
        checkOutput("hold_release", 1'b0, 1'b0, 32'h0);
        runAccess("rd_word_020", 1'b1, 1'b1, 10'h020, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Reset during WAIT of a write aborts it
        applyStimulus(1'b1, 1'b0, 1'b1, 10'h010, 32'h1111_1111);
        @(posedge Clk); #1;
        checkBit("abort.MFC_k0", MFC, 1'b0);
        @(posedge Clk); #1;
        checkOutput("abort.in_wait", 1'b0, 1'b0, 32'hCAFE_F00D);
        #2 Reset = 1'b1;
        #1;
        checkOutput("abort.reset", 1'b0, 1'b0, 32'h0);
        @(negedge Clk);
        MFA = 1'b0;
        @(posedge Clk); #1;
        checkOutput("abort.held", 1'b0, 1'b0, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        checkBit("abort.idle_MFC", MFC, 1'b0);
        runAccess("rd_word_after_abort", 1'b1, 1'b1, 10'h010, 32'h0, 32'hDEAD_BE5A, 1'b0);

        $display("[TB] %0d tests run, %0d failed", numTests, numFail);
        $finish;
    end

endmodule
